// File: rtl/decode_pipe.sv
// RV32I decode stage: combinational decode into an output register backed by a
// one-entry skid register. Optional M extension decode under DECODE_M_EXT_EN.
package instr_type;
  typedef enum logic [5:0] {
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, FENCE_I, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
`ifdef DECODE_M_EXT_EN
    , MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
`endif
  } instr_kind_t;
endpackage

module decode_pipe
  import instr_type::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output instr_kind_t           out_kind,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [PC_W-1:0]       out_pc,
  output logic                  out_write_reserve,
  output logic                  out_illegal
);

  typedef struct packed {
    instr_kind_t           kind;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [PC_W-1:0]       pc;
    logic                  wr;
    logic                  ill;
  } bundle_t;

  bundle_t dec, out_q, skid_q;
  logic    ov, sv;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    dec      = '0;
    dec.kind = ADDI;
    dec.rs1  = REG_ADDR_W'(in_instr[19:15]);
    dec.rs2  = REG_ADDR_W'(in_instr[24:20]);
    dec.rd   = REG_ADDR_W'(in_instr[11:7]);
    dec.pc   = in_pc;
    if (in_instr[1:0] != 2'b11) begin
      dec.ill = 1'b1;
    end else begin
      case (op)
        7'b0110111: begin dec.kind = LUI;   dec.imm = imm_u; dec.wr = 1'b1; end
        7'b0010111: begin dec.kind = AUIPC; dec.imm = imm_u; dec.wr = 1'b1; end
        7'b1101111: begin dec.kind = JAL;   dec.imm = imm_j; dec.wr = 1'b1; end
        7'b1100111: begin dec.kind = JALR;  dec.imm = imm_i; dec.wr = 1'b1; end
        7'b1100011: begin
          dec.imm = imm_b;
          case (f3)
            3'd0: dec.kind = BEQ;
            3'd1: dec.kind = BNE;
            3'd4: dec.kind = BLT;
            3'd5: dec.kind = BGE;
            3'd6: dec.kind = BLTU;
            3'd7: dec.kind = BGEU;
            default: dec.ill = 1'b1;
          endcase
        end
        7'b0000011: begin
          dec.imm = imm_i;
          dec.wr  = 1'b1;
          case (f3)
            3'd0: dec.kind = LB;
            3'd1: dec.kind = LH;
            3'd2: dec.kind = LW;
            3'd4: dec.kind = LBU;
            3'd5: dec.kind = LHU;
            default: dec.ill = 1'b1;
          endcase
        end
        7'b0100011: begin
          dec.imm = imm_s;
          case (f3)
            3'd0: dec.kind = SB;
            3'd1: dec.kind = SH;
            3'd2: dec.kind = SW;
            default: dec.ill = 1'b1;
          endcase
        end
        7'b0010011: begin
          dec.imm = imm_i;
          dec.wr  = 1'b1;
          case (f3)
            3'd0: dec.kind = ADDI;
            3'd2: dec.kind = SLTI;
            3'd3: dec.kind = SLTIU;
            3'd4: dec.kind = XORI;
            3'd6: dec.kind = ORI;
            3'd7: dec.kind = ANDI;
            3'd1: begin
              dec.imm = imm_sh;
              if (f7 == 7'b0000000) dec.kind = SLLI;
              else                  dec.ill  = 1'b1;
            end
            default: begin
              dec.imm = imm_sh;
              if      (f7 == 7'b0000000) dec.kind = SRLI;
              else if (f7 == 7'b0100000) dec.kind = SRAI;
              else                       dec.ill  = 1'b1;
            end
          endcase
        end
        7'b0110011: begin
          dec.wr = 1'b1;
          if (f7 == 7'b0000000) begin
            case (f3)
              3'd0: dec.kind = ADD;
              3'd1: dec.kind = SLL;
              3'd2: dec.kind = SLT;
              3'd3: dec.kind = SLTU;
              3'd4: dec.kind = XOR;
              3'd5: dec.kind = SRL;
              3'd6: dec.kind = OR;
              default: dec.kind = AND;
            endcase
          end else if (f7 == 7'b0100000) begin
            if      (f3 == 3'd0) dec.kind = SUB;
            else if (f3 == 3'd5) dec.kind = SRA;
            else                 dec.ill  = 1'b1;
`ifdef DECODE_M_EXT_EN
          end else if (f7 == 7'b0000001) begin
            case (f3)
              3'd0: dec.kind = MUL;
              3'd1: dec.kind = MULH;
              3'd2: dec.kind = MULHSU;
              3'd3: dec.kind = MULHU;
              3'd4: dec.kind = DIV;
              3'd5: dec.kind = DIVU;
              3'd6: dec.kind = REM;
              default: dec.kind = REMU;
            endcase
`endif
          end else begin
            dec.ill = 1'b1;
          end
        end
        7'b0001111: dec.kind = (f3 == 3'd1) ? FENCE_I : FENCE;
        7'b1110011: begin
          dec.imm = imm_i;
          dec.wr  = 1'b1;
          case (f3)
            3'd0: begin
              dec.wr = 1'b0;
              if      (in_instr[31:20] == 12'd0) dec.kind = ECALL;
              else if (in_instr[31:20] == 12'd1) dec.kind = EBREAK;
              else                               dec.ill  = 1'b1;
            end
            3'd1: dec.kind = CSRRW;
            3'd2: dec.kind = CSRRS;
            3'd3: dec.kind = CSRRC;
            3'd5: dec.kind = CSRRWI;
            3'd6: dec.kind = CSRRSI;
            3'd7: dec.kind = CSRRCI;
            default: dec.ill = 1'b1;
          endcase
        end
        default: dec.ill = 1'b1;
      endcase
    end
    // Illegal bundles carry a harmless ADDI shape so downstream never writes.
    if (dec.ill) begin
      dec.kind = ADDI;
      dec.imm  = '0;
      dec.wr   = 1'b0;
    end
    if (dec.rd == '0) dec.wr = 1'b0;
  end

  logic acc, out_load;
  assign in_ready = ~sv;
  assign acc      = in_valid & in_ready;
  assign out_load = ~ov | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov          <= 1'b0;
      sv          <= 1'b0;
      out_q       <= '0;
      out_q.kind  <= ADDI;
      skid_q      <= '0;
      skid_q.kind <= ADDI;
    end else if (flush) begin
      ov <= 1'b0;
      sv <= 1'b0;
    end else if (out_load) begin
      if (sv) begin
        out_q <= skid_q;
        ov    <= 1'b1;
        if (acc) skid_q <= dec;
        sv <= acc;
      end else begin
        if (acc) out_q <= dec;
        ov <= acc;
      end
    end else if (acc) begin
      // Output stalled: park the new bundle behind it.
      skid_q <= dec;
      sv     <= 1'b1;
    end
  end

  assign out_valid         = ov;
  assign out_kind          = out_q.kind;
  assign out_rs1           = out_q.rs1;
  assign out_rs2           = out_q.rs2;
  assign out_rd            = out_q.rd;
  assign out_imm           = out_q.imm;
  assign out_pc            = out_q.pc;
  assign out_write_reserve = out_q.wr;
  assign out_illegal       = out_q.ill;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed-vector bench for decode_pipe: decode table, handshake, flush, reset.
module tb_decode_pipe;
  import instr_type::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  instr_kind_t out_kind;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  logic        out_write_reserve, out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  decode_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_pc(out_pc), .out_write_reserve(out_write_reserve), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if ({out_valid, in_ready, out_kind, out_imm, out_pc, out_rs1, out_rs2, out_rd,
         out_write_reserve, out_illegal} !== {1'b0, 1'b1, ADDI, 32'd0, 32'd0, 15'd0, 2'b00}) begin
      n_err++;
      $display("FAIL reset_state: valid=%b rdy=%b kind=%0d imm=%h pc=%h wr=%b ill=%b",
               out_valid, in_ready, out_kind, out_imm, out_pc, out_write_reserve, out_illegal);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_decode_table();
    logic [31:0] ins [16];
    instr_kind_t ek  [16];
    logic [31:0] eimm[16];
    logic        ewr [16];
    logic        eill[16];
    ins  = '{32'h00500093, 32'hFE208CE3, 32'h123452B7, 32'h12345037,
             32'hFE20AE23, 32'hFFDFF0EF, 32'h4070D193, 32'h40709193,
             32'h402081B3, 32'h00000000, 32'h00000073, 32'h00100073,
             32'h00200073, 32'hFFF00093, 32'h0000007F, 32'h00002063};
    ek   = '{ADDI, BEQ, LUI, LUI, SW, JAL, SRAI, ADDI,
             SUB, ADDI, ECALL, EBREAK, ADDI, ADDI, ADDI, ADDI};
    eimm = '{32'h5, 32'hFFFFFFF8, 32'h12345000, 32'h12345000,
             32'hFFFFFFFC, 32'hFFFFFFFC, 32'h7, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    ewr  = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    eill = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(ins[i], 32'(i * 4));
      n_cmp++;
      if ({out_valid, out_kind, out_imm, out_pc, out_write_reserve, out_illegal} !==
          {1'b1, ek[i], eimm[i], 32'(i * 4), ewr[i], eill[i]}) begin
        n_err++;
        $display("FAIL decode[%0d] %h: got v=%b k=%0d imm=%h pc=%h wr=%b ill=%b, want k=%0d imm=%h wr=%b ill=%b",
                 i, ins[i], out_valid, out_kind, out_imm, out_pc, out_write_reserve, out_illegal,
                 ek[i], eimm[i], ewr[i], eill[i]);
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_idle: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_fields();
    send(32'h00500093, 32'h100);
    n_cmp++;
    if ({out_rd, out_rs1} !== {5'd1, 5'd0}) begin
      n_err++;
      $display("FAIL addi_regs: rd=%0d rs1=%0d want 1 0", out_rd, out_rs1);
    end
    send(32'hFE208CE3, 32'h104);
    n_cmp++;
    if ({out_rs1, out_rs2} !== {5'd1, 5'd2}) begin
      n_err++;
      $display("FAIL beq_regs: rs1=%0d rs2=%0d want 1 2", out_rs1, out_rs2);
    end
  endtask

  task automatic test_m_ext();
    send(32'h022081B3, 32'h200);
`ifdef DECODE_M_EXT_EN
    n_cmp++;
    if ({out_kind, out_rd, out_write_reserve, out_illegal} !== {MUL, 5'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mul_decode: k=%0d rd=%0d wr=%b ill=%b want MUL 3 1 0",
               out_kind, out_rd, out_write_reserve, out_illegal);
    end
`else
    n_cmp++;
    if ({out_kind, out_rd, out_write_reserve, out_illegal} !== {ADDI, 5'd3, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mul_illegal: k=%0d rd=%0d wr=%b ill=%b want ADDI 3 0 1",
               out_kind, out_rd, out_write_reserve, out_illegal);
    end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_pc = 32'h0;
    tick();
    n_cmp++;
    if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL bp_first: v=%b rdy=%b pc=%h want 1 1 0", out_valid, in_ready, out_pc);
    end
    in_instr = 32'h00200093; in_pc = 32'h4;
    tick();
    n_cmp++;
    if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL bp_full: v=%b rdy=%b pc=%h want 1 0 0", out_valid, in_ready, out_pc);
    end
    in_instr = 32'h00300093; in_pc = 32'h8;
    tick();
    n_cmp++;
    if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL bp_hold: v=%b rdy=%b pc=%h want 1 0 0", out_valid, in_ready, out_pc);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, in_ready, out_pc, out_imm} !== {1'b1, 1'b1, 32'h4, 32'h2}) begin
      n_err++;
      $display("FAIL bp_second: v=%b rdy=%b pc=%h imm=%h want 1 1 4 2",
               out_valid, in_ready, out_pc, out_imm);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_pc, out_imm} !== {1'b1, 32'h8, 32'h3}) begin
      n_err++;
      $display("FAIL bp_third: v=%b pc=%h imm=%h want 1 8 3", out_valid, out_pc, out_imm);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00100093, 32'h40);
    send(32'h00200093, 32'h44);
    n_cmp++;
    if ({out_valid, in_ready} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL flush_setup: v=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300093; in_pc = 32'h48;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_clear: v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_ghost[%0d]: out_valid=%b pc=%h want 0", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(32'h00100093, 32'h80);
    send(32'h00200093, 32'h84);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_pc, out_kind} !== {1'b0, 1'b1, 32'h0, ADDI}) begin
      n_err++;
      $display("FAIL async_reset: v=%b rdy=%b pc=%h k=%0d want 0 1 0 ADDI",
               out_valid, in_ready, out_pc, out_kind);
    end
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_fields();
    test_m_ext();
    tick();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
